cap_touch_scanner: RTL

Time-multiplexed controller for capacitive touch pads. It sequences discharge/release/measure cycles across NUM_PADS pads using one shared cycle counter. On the first scan it captures a per-pad baseline; after that it reports per-pad touch state with hysteresis. It sits between the top-level bidirectional uio pads (external pull-up per pad) and user logic, and extends the single-pad capacitive touch sensor to multiple channels.

---
 rtl/cap_touch_scanner.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/cap_touch_scanner.sv
// cap_touch_scanner: time-multiplexed capacitive touch controller.
// Each pad in turn is discharged (all pads held low), then released while a
// shared counter measures how long the externally pulled-up pad takes to read
// high through a 2-flop synchronizer. The first pass (and any pass requested
// by recal) records per-pad baselines; later passes drive touched[] with
// hysteresis around baseline + thr.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   enable         scan while high; the pad in flight always completes
//   recal          single-cycle request for a new baseline pass
//   thr            touch threshold above baseline (static while enabled)
//   pad_in         raw asynchronous pad levels
//   pad_out        pad drive value, constant 0
//   pad_oe         1 = drive pad low, 0 = release
//   touched        per-pad touch state
//   cal_done       every pad holds a valid baseline
//   sample_valid   one-cycle pulse per completed measurement
//   sample_pad     pad index of the latest sample
//   sample_count   measured count of the latest sample
module cap_touch_scanner #(
    parameter int unsigned NUM_PADS         = 4,
    parameter int unsigned CNT_W            = 12,
    parameter int unsigned DISCHARGE_CYCLES = 64,
    parameter int unsigned TIMEOUT          = 4095
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        recal,
    input  logic [CNT_W-1:0]            thr,
    input  logic [NUM_PADS-1:0]         pad_in,
    output logic [NUM_PADS-1:0]         pad_out,
    output logic [NUM_PADS-1:0]         pad_oe,
    output logic [NUM_PADS-1:0]         touched,
    output logic                        cal_done,
    output logic                        sample_valid,
    output logic [$clog2(NUM_PADS)-1:0] sample_pad,
    output logic [CNT_W-1:0]            sample_count
);

    localparam int unsigned PW = $clog2(NUM_PADS);
    localparam int unsigned DW = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;

    localparam logic [PW-1:0]    LAST_PAD = PW'(NUM_PADS - 1);
    localparam logic [DW-1:0]    DIS_LAST = DW'(DISCHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISCHARGE,
        S_MEASURE,
        S_EVAL
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [PW-1:0]         r_p, w_p_nxt;
    logic [DW-1:0]         r_dcnt, w_dcnt_nxt;
    logic [CNT_W-1:0]      r_count, w_count_nxt;
    logic [NUM_PADS-1:0]   r_sync1, r_psync;
    logic [CNT_W-1:0]      r_baseline [NUM_PADS];
    logic [CNT_W-1:0]      w_baseline_nxt [NUM_PADS];
    logic [NUM_PADS-1:0]   r_touched, w_touched_nxt;
    logic                  r_cal_pend, w_cal_pend_nxt;
    logic                  r_cal_act, w_cal_act_nxt;
    logic                  r_cal_done, w_cal_done_nxt;
    logic [NUM_PADS-1:0]   r_pad_oe, w_pad_oe_nxt;
    logic                  r_sample_valid, w_sample_valid_nxt;
    logic [PW-1:0]         r_sample_pad, w_sample_pad_nxt;
    logic [CNT_W-1:0]      r_sample_count, w_sample_count_nxt;
    logic                  w_cal_start;

    // Hysteresis levels use one extra bit so baseline + thr cannot wrap.
    logic [CNT_W:0]        w_meas, w_set_lvl, w_clr_lvl;

    assign w_meas    = {1'b0, r_count};
    assign w_set_lvl = {1'b0, r_baseline[r_p]} + {1'b0, thr};
    assign w_clr_lvl = {1'b0, r_baseline[r_p]} + {2'b00, thr[CNT_W-1:1]};

    assign pad_out      = '0;
    assign pad_oe       = r_pad_oe;
    assign touched      = r_touched;
    assign cal_done     = r_cal_done;
    assign sample_valid = r_sample_valid;
    assign sample_pad   = r_sample_pad;
    assign sample_count = r_sample_count;

    // Pad level synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_psync <= '0;
        end else begin
            r_sync1 <= pad_in;
            r_psync <= r_sync1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_p            <= '0;
            r_dcnt         <= '0;
            r_count        <= '0;
            for (int i = 0; i < int'(NUM_PADS); i++) begin
                r_baseline[i] <= '0;
            end
            r_touched      <= '0;
            r_cal_pend     <= 1'b1;
            r_cal_act      <= 1'b0;
            r_cal_done     <= 1'b0;
            r_pad_oe       <= '0;
            r_sample_valid <= 1'b0;
            r_sample_pad   <= '0;
            r_sample_count <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_p            <= w_p_nxt;
            r_dcnt         <= w_dcnt_nxt;
            r_count        <= w_count_nxt;
            r_baseline     <= w_baseline_nxt;
            r_touched      <= w_touched_nxt;
            r_cal_pend     <= w_cal_pend_nxt;
            r_cal_act      <= w_cal_act_nxt;
            r_cal_done     <= w_cal_done_nxt;
            r_pad_oe       <= w_pad_oe_nxt;
            r_sample_valid <= w_sample_valid_nxt;
            r_sample_pad   <= w_sample_pad_nxt;
            r_sample_count <= w_sample_count_nxt;
        end
    end

    // Next-state, calibration and output logic.
    always_comb begin
        w_state_nxt        = r_state;
        w_p_nxt            = r_p;
        w_dcnt_nxt         = r_dcnt;
        w_count_nxt        = r_count;
        w_baseline_nxt     = r_baseline;
        w_touched_nxt      = r_touched;
        w_cal_pend_nxt     = r_cal_pend | recal;
        w_cal_act_nxt      = r_cal_act;
        w_cal_done_nxt     = r_cal_done;
        w_sample_pad_nxt   = r_sample_pad;
        w_sample_count_nxt = r_sample_count;
        w_cal_start        = 1'b0;
        w_pad_oe_nxt       = '0;
        w_sample_valid_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cal_start = r_cal_pend && (r_p == '0);
                if (enable) begin
                    w_dcnt_nxt  = '0;
                    w_state_nxt = S_DISCHARGE;
                end
            end
            S_DISCHARGE: begin
                w_dcnt_nxt = r_dcnt + 1'b1;
                if (r_dcnt == DIS_LAST) begin
                    w_count_nxt = '0;
                    w_state_nxt = S_MEASURE;
                end
            end
            S_MEASURE: begin
                // Pad-high takes priority over timeout; either way r_count is the capture.
                if (r_psync[r_p] || (r_count == CNT_MAX)) begin
                    w_state_nxt        = S_EVAL;
                    w_sample_pad_nxt   = r_p;
                    w_sample_count_nxt = r_count;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            S_EVAL: begin
                if (r_cal_act) begin
                    w_baseline_nxt[r_p] = r_count;
                    w_touched_nxt[r_p]  = 1'b0;
                end else if (w_meas >= w_set_lvl) begin
                    w_touched_nxt[r_p] = 1'b1;
                end else if (w_meas < w_clr_lvl) begin
                    w_touched_nxt[r_p] = 1'b0;
                end
                if (r_p == LAST_PAD) begin
                    w_p_nxt = '0;
                    if (r_cal_act) begin
                        w_cal_act_nxt  = 1'b0;
                        w_cal_done_nxt = 1'b1;
                    end
                    // Only a request already latched counts; a same-cycle recal waits a round.
                    w_cal_start = r_cal_pend;
                end else begin
                    w_p_nxt = r_p + 1'b1;
                end
                if (enable) begin
                    w_dcnt_nxt  = '0;
                    w_state_nxt = S_DISCHARGE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A new baseline pass invalidates calibration and all touch state.
        if (w_cal_start) begin
            w_cal_act_nxt  = 1'b1;
            w_cal_done_nxt = 1'b0;
            w_touched_nxt  = '0;
            w_cal_pend_nxt = recal;
        end

        // Pad drive follows the state being entered so it lines up with the FSM.
        case (w_state_nxt)
            S_DISCHARGE:        w_pad_oe_nxt = '1;
            S_MEASURE, S_EVAL:  w_pad_oe_nxt = ~(NUM_PADS'(1) << w_p_nxt);
            default:            w_pad_oe_nxt = '0;
        endcase

        w_sample_valid_nxt = (w_state_nxt == S_EVAL);
    end

endmodule
